// File: rtl/beat_pkg.sv
// ============================================================================
// Module : beat_pkg
// Brief  : Shared types, constants and entry field helpers for beat_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package beat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REC     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_P_FETCH = 3'd3,
        ST_P_HOLD  = 3'd4
    } state_t;

    localparam int              KEY_W       = 7;
    localparam logic [KEY_W-1:0] KEY_SILENT = '0;

    // Helpers work on a widest-case container; callers cast to their real width.
    localparam int DUR_MAX_W   = 16;
    localparam int ENTRY_MAX_W = KEY_W + DUR_MAX_W;

    function automatic int entry_w(input int dur_w);
        return KEY_W + dur_w;
    endfunction

    function automatic logic [ENTRY_MAX_W-1:0] entry_pack(
        input logic [KEY_W-1:0]     key,
        input logic [DUR_MAX_W-1:0] dur,
        input int                   dur_w
    );
        return (ENTRY_MAX_W'(key) << dur_w) | ENTRY_MAX_W'(dur);
    endfunction

    function automatic logic [KEY_W-1:0] entry_key(
        input logic [ENTRY_MAX_W-1:0] e,
        input int                     dur_w
    );
        return KEY_W'(e >> dur_w);
    endfunction

    function automatic logic [DUR_MAX_W-1:0] entry_dur(
        input logic [ENTRY_MAX_W-1:0] e,
        input int                     dur_w
    );
        logic [ENTRY_MAX_W-1:0] mask;
        mask = ~({ENTRY_MAX_W{1'b1}} << dur_w);
        return DUR_MAX_W'(e & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/beat_sequencer_if.sv
// ============================================================================
// Module : beat_sequencer_if
// Brief  : Control, key stream and status bundle of the beat sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beat_sequencer_if #(
    parameter int DEPTH_LOG2 = 6
) ();
    import beat_pkg::*;

    logic [KEY_W-1:0]    key_in;
    logic                rec_start;
    logic                rec_stop;
    logic                play_start;
    logic                play_stop;
    logic                loop_en;
    logic [KEY_W-1:0]    key_out;
    logic                recording;
    logic                playing;
    logic                full;
    logic [DEPTH_LOG2:0] entry_count;

    modport master (
        output key_in, rec_start, rec_stop, play_start, play_stop, loop_en,
        input  key_out, recording, playing, full, entry_count
    );

    modport slave (
        input  key_in, rec_start, rec_stop, play_start, play_stop, loop_en,
        output key_out, recording, playing, full, entry_count
    );

endinterface

`default_nettype wire

// File: rtl/beat_mem.sv
// ============================================================================
// Module : beat_mem
// Brief  : Simple dual-port synchronous RAM, registered read, no content reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_mem #(
    parameter int ADDR_W = 6,
    parameter int WIDTH  = 15
) (
    input  wire logic              clock,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]  i_wr_data,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [1<<ADDR_W];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= mem[i_rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/beat_sequencer.sv
// ============================================================================
// Module : beat_sequencer
// Brief  : Records a key stream as run-length {key, ticks} entries and replays it.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_sequencer
    import beat_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int DEPTH_LOG2 = 6,
    parameter int DUR_W      = 8
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    beat_sequencer_if.slave    bus
);

    localparam int ENTRY_W = entry_w(DUR_W);
    localparam int DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W   = DEPTH_LOG2 + 1;

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_ONE   = DIV_W'(1);
    localparam logic [DUR_W-1:0]      DUR_MAX   = '1;
    localparam logic [DUR_W-1:0]      DUR_ONE   = DUR_W'(1);
    localparam logic [DUR_W-1:0]      DUR_ZERO  = '0;
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(1 << DEPTH_LOG2);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'((1 << DEPTH_LOG2) - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = '0;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      entry_count_q, entry_count_d;
    logic [KEY_W-1:0]      run_key_q, run_key_d;
    logic [DUR_W-1:0]      run_dur_q, run_dur_d;
    logic [DUR_W-1:0]      dur_cnt_q, dur_cnt_d;
    logic [KEY_W-1:0]      key_out_q, key_out_d;

    logic                  tick;
    logic                  clear_div;
    logic                  wr_en;
    logic [ENTRY_W-1:0]    wr_data;
    logic [ENTRY_W-1:0]    rd_data;
    logic [KEY_W-1:0]      t_key;
    logic [DUR_W-1:0]      t_dur;
    logic                  t_write;
    logic                  last_entry;

    assign tick       = (div_q == DIV_LAST);
    assign div_d      = (clear_div || tick) ? '0 : div_q + DIV_ONE;
    assign last_entry = ({1'b0, rptr_q} == (entry_count_q - CNT_ONE));

    // Reading at the next pointer lets the entry be ready during P_FETCH,
    // so key_out can be registered on the way into P_HOLD.
    beat_mem #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (ENTRY_W)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (wr_en),
        .i_wr_addr (entry_count_q[DEPTH_LOG2-1:0]),
        .i_wr_data (wr_data),
        .i_rd_addr (rptr_d),
        .o_rd_data (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        rptr_d        = rptr_q;
        entry_count_d = entry_count_q;
        run_key_d     = run_key_q;
        run_dur_d     = run_dur_q;
        dur_cnt_d     = dur_cnt_q;
        key_out_d     = key_out_q;
        clear_div     = 1'b0;
        wr_en         = 1'b0;
        wr_data       = ENTRY_W'(entry_pack(run_key_q, DUR_MAX_W'(run_dur_q), DUR_W));
        t_key         = run_key_q;
        t_dur         = run_dur_q;
        t_write       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                key_out_d = KEY_SILENT;
                if (bus.rec_start) begin
                    state_d       = ST_REC;
                    entry_count_d = CNT_ZERO;
                    run_key_d     = bus.key_in;
                    run_dur_d     = DUR_ZERO;
                    clear_div     = 1'b1;
                end else if (bus.play_start && (entry_count_q != CNT_ZERO)) begin
                    state_d   = ST_P_FETCH;
                    rptr_d    = PTR_ZERO;
                    clear_div = 1'b1;
                end
            end

            ST_REC: begin
                if (tick) begin
                    if ((bus.key_in == run_key_q) && (run_dur_q != DUR_MAX)) begin
                        t_dur = run_dur_q + DUR_ONE;
                    end else begin
                        t_write = (run_dur_q != DUR_ZERO);
                        t_key   = bus.key_in;
                        t_dur   = DUR_ONE;
                    end
                end
                run_key_d = t_key;
                run_dur_d = t_dur;
                if (t_write) begin
                    wr_en         = 1'b1;
                    entry_count_d = entry_count_q + CNT_ONE;
                end

                if (t_write && (entry_count_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    run_dur_d = DUR_ZERO;
                end else if (bus.rec_stop) begin
                    // A tick write already used the port: defer the flush a cycle.
                    if (t_write) begin
                        state_d = ST_FLUSH;
                    end else begin
                        if (t_dur != DUR_ZERO) begin
                            wr_en         = 1'b1;
                            wr_data       = ENTRY_W'(entry_pack(t_key, DUR_MAX_W'(t_dur), DUR_W));
                            entry_count_d = entry_count_q + CNT_ONE;
                        end
                        run_dur_d = DUR_ZERO;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                if (run_dur_q != DUR_ZERO) begin
                    wr_en         = 1'b1;
                    entry_count_d = entry_count_q + CNT_ONE;
                end
                run_dur_d = DUR_ZERO;
                state_d   = ST_IDLE;
            end

            ST_P_FETCH: begin
                if (bus.play_stop) begin
                    state_d   = ST_IDLE;
                    key_out_d = KEY_SILENT;
                end else begin
                    state_d   = ST_P_HOLD;
                    key_out_d = entry_key(ENTRY_MAX_W'(rd_data), DUR_W);
                    dur_cnt_d = DUR_W'(entry_dur(ENTRY_MAX_W'(rd_data), DUR_W));
                end
            end

            ST_P_HOLD: begin
                if (bus.play_stop) begin
                    state_d   = ST_IDLE;
                    key_out_d = KEY_SILENT;
                end else if (tick) begin
                    if (dur_cnt_q > DUR_ONE) begin
                        dur_cnt_d = dur_cnt_q - DUR_ONE;
                    end else if (last_entry && !bus.loop_en) begin
                        state_d   = ST_IDLE;
                        key_out_d = KEY_SILENT;
                    end else begin
                        rptr_d    = last_entry ? PTR_ZERO : rptr_q + PTR_ONE;
                        state_d   = ST_P_FETCH;
                        clear_div = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                key_out_d = KEY_SILENT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            rptr_q        <= '0;
            entry_count_q <= '0;
            run_key_q     <= '0;
            run_dur_q     <= '0;
            dur_cnt_q     <= '0;
            key_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            rptr_q        <= rptr_d;
            entry_count_q <= entry_count_d;
            run_key_q     <= run_key_d;
            run_dur_q     <= run_dur_d;
            dur_cnt_q     <= dur_cnt_d;
            key_out_q     <= key_out_d;
        end
    end

    assign bus.key_out     = key_out_q;
    assign bus.recording   = (state_q == ST_REC) || (state_q == ST_FLUSH);
    assign bus.playing     = (state_q == ST_P_FETCH) || (state_q == ST_P_HOLD);
    assign bus.full        = (entry_count_q == CNT_FULL);
    assign bus.entry_count = entry_count_q;

endmodule

`default_nettype wire

// File: tb/tb_beat_sequencer.sv
// ============================================================================
// Module : tb_beat_sequencer
// Brief  : Scoreboard bench for beat_sequencer (TICK_DIV=4, depth 4, 4-bit dur).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beat_sequencer;

    localparam int TD      = 4;
    localparam int DEPTH   = 4;
    localparam int DUR_MAX = 15;

    typedef struct {
        logic [6:0] key;
        int         dur;
    } ent_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    beat_sequencer_if #(.DEPTH_LOG2(2)) bus ();

    beat_sequencer #(
        .TICK_DIV   (TD),
        .DEPTH_LOG2 (2),
        .DUR_W      (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    ent_t       model[$];
    logic [6:0] tick_keys[$];
    logic [6:0] sb[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drives one recording (one key per tick) and builds the expected entry list.
    task automatic run_record(input logic [6:0] start_key, input bit stop_on_tick);
        logic [6:0] rk;
        int         rd;
        bit         stopped;
        int         n;
        model.delete();
        rk = start_key; rd = 0; stopped = 1'b0;
        foreach (tick_keys[i]) begin
            if (!stopped) begin
                if (tick_keys[i] == rk && rd != DUR_MAX) begin
                    rd++;
                end else begin
                    if (rd != 0) begin
                        model.push_back('{key: rk, dur: rd});
                        if (model.size() == DEPTH) stopped = 1'b1;
                    end
                    rk = tick_keys[i];
                    rd = 1;
                end
            end
        end
        if (!stopped && rd != 0) model.push_back('{key: rk, dur: rd});

        n = tick_keys.size();
        bus.key_in = start_key; bus.rec_start = 1'b1; cyc(); bus.rec_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.key_in = tick_keys[i];
            if (stop_on_tick && i == n - 1) begin
                repeat (TD - 1) cyc();
                bus.rec_stop = 1'b1; cyc(); bus.rec_stop = 1'b0;
            end else begin
                repeat (TD) cyc();
            end
        end
        if (!stop_on_tick) begin
            bus.rec_stop = 1'b1; cyc(); bus.rec_stop = 1'b0;
        end
        repeat (2) cyc();
        bus.key_in = 7'h00;
    endtask

    // Expected key_out per cycle for a one-shot playback; the last entry has
    // no trailing fetch cycle, so it is one cycle shorter.
    task automatic build_sb_once();
        int reps;
        sb.delete();
        sb.push_back(7'h00);
        for (int i = 0; i < model.size(); i++) begin
            reps = TD * model[i].dur - ((i == model.size() - 1) ? 1 : 0);
            repeat (reps) sb.push_back(model[i].key);
        end
        sb.push_back(7'h00);
    endtask

    task automatic start_play();
        bus.play_start = 1'b1; cyc(); bus.play_start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.key_out, bus.recording, bus.playing, bus.full} !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs: got key_out=%0h rec=%0b play=%0b full=%0b expected all 0",
                     bus.key_out, bus.recording, bus.playing, bus.full);
        end
        checks++;
        if (bus.entry_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", bus.entry_count);
        end
    endtask

    task automatic test_play_empty(input string name);
        start_play();
        cyc();
        checks++;
        if (bus.playing !== 1'b0 || bus.key_out !== 7'h00) begin
            failures++;
            $display("FAIL %s: got playing=%0b key_out=%0h expected 0/0", name, bus.playing, bus.key_out);
        end
    endtask

    task automatic test_record(input string name, input logic [6:0] start_key, input bit stop_on_tick);
        run_record(start_key, stop_on_tick);
        checks++;
        if (bus.entry_count !== 3'(model.size())) begin
            failures++;
            $display("FAIL %s_count: got %0d expected %0d", name, bus.entry_count, model.size());
        end
        checks++;
        if (bus.recording !== 1'b0 || bus.full !== (model.size() == DEPTH)) begin
            failures++;
            $display("FAIL %s_status: got rec=%0b full=%0b expected rec=0 full=%0b",
                     name, bus.recording, bus.full, model.size() == DEPTH);
        end
    endtask

    task automatic test_playback(input string name);
        logic [6:0] exp;
        int         cycle;
        bus.loop_en = 1'b0;
        build_sb_once();
        start_play();
        cycle = 1;
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            checks++;
            if (bus.key_out !== exp) begin
                failures++;
                $display("FAIL %s_key cycle %0d: got %0h expected %0h", name, cycle, bus.key_out, exp);
            end
            if (sb.size() != 0) begin
                cyc();
                cycle++;
            end
        end
        checks++;
        if (bus.playing !== 1'b0) begin
            failures++;
            $display("FAIL %s_end: got playing=%0b expected 0", name, bus.playing);
        end
    endtask

    task automatic test_loop();
        logic [6:0] exp;
        bus.loop_en = 1'b1;
        sb.delete();
        sb.push_back(7'h00);
        foreach (model[i]) repeat (TD * model[i].dur) sb.push_back(model[i].key);
        repeat (2) sb.push_back(model[0].key);
        start_play();
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            checks++;
            if (bus.key_out !== exp) begin
                failures++;
                $display("FAIL loop_key: got %0h expected %0h (%0d left)", bus.key_out, exp, sb.size());
            end
            if (sb.size() != 0) cyc();
        end
        bus.play_stop = 1'b1; cyc(); bus.play_stop = 1'b0;
        checks++;
        if (bus.key_out !== 7'h00 || bus.playing !== 1'b0) begin
            failures++;
            $display("FAIL loop_stop: got key_out=%0h playing=%0b expected 0/0", bus.key_out, bus.playing);
        end
        bus.loop_en = 1'b0;
    endtask

    task automatic test_play_stop();
        start_play();
        repeat (3) cyc();
        checks++;
        if (bus.playing !== 1'b1 || bus.key_out !== model[0].key) begin
            failures++;
            $display("FAIL stop_hold: got playing=%0b key_out=%0h expected 1/%0h",
                     bus.playing, bus.key_out, model[0].key);
        end
        bus.play_stop = 1'b1; cyc(); bus.play_stop = 1'b0;
        checks++;
        if (bus.key_out !== 7'h00 || bus.playing !== 1'b0 || bus.entry_count !== 3'(model.size())) begin
            failures++;
            $display("FAIL stop_after: got key_out=%0h playing=%0b count=%0d expected 0/0/%0d",
                     bus.key_out, bus.playing, bus.entry_count, model.size());
        end
    endtask

    task automatic test_reset_mid_rec();
        bus.key_in = 7'h41;
        bus.rec_start = 1'b1; cyc(); bus.rec_start = 1'b0;
        repeat (5) cyc();
        checks++;
        if (bus.recording !== 1'b1) begin
            failures++;
            $display("FAIL midrec_active: got recording=%0b expected 1", bus.recording);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.key_out, bus.recording, bus.playing, bus.full, bus.entry_count} !== 13'h0) begin
            failures++;
            $display("FAIL midrec_reset: got key_out=%0h rec=%0b play=%0b full=%0b count=%0d expected all 0",
                     bus.key_out, bus.recording, bus.playing, bus.full, bus.entry_count);
        end
        cyc();
        resetn = 1'b1;
        bus.key_in = 7'h00;
        cyc();
    endtask

    initial begin
        bus.key_in     = 7'h00;
        bus.rec_start  = 1'b0;
        bus.rec_stop   = 1'b0;
        bus.play_start = 1'b0;
        bus.play_stop  = 1'b0;
        bus.loop_en    = 1'b0;
        repeat (2) cyc();
        test_reset();
        resetn = 1'b1;
        cyc();

        test_play_empty("play_empty_after_reset");

        tick_keys = '{7'h61, 7'h61, 7'h61, 7'h62, 7'h62};
        test_record("rec_basic", 7'h61, 1'b0);
        test_playback("play_basic");

        tick_keys = '{7'h61, 7'h61, 7'h62};
        test_record("rec_stop_on_tick", 7'h61, 1'b1);
        test_playback("play_stop_on_tick");

        tick_keys.delete();
        repeat (20) tick_keys.push_back(7'h61);
        test_record("rec_long", 7'h61, 1'b0);
        test_playback("play_long");

        tick_keys = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h35};
        test_record("rec_full", 7'h31, 1'b0);
        test_loop();
        test_play_stop();

        test_reset_mid_rec();
        test_play_empty("play_empty_after_midrec_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
